multicycle_control: RTL

//  Multi-cycle main control FSM for the RV32 datapath. It is the successor to the single-cycle opcode decoder.
//  - Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
//  - Handshakes with a shared instruction/data memory via mem_ready, with a wait timeout.
//  - Adds I-type ALU and JAL support, plus illegal-opcode and memory-timeout traps.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle main FSM and the RV32 datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal, mem_err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal, mem_err, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a memory wait timeout and sticky illegal-opcode / memory-timeout traps.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_W        = 5,
    parameter bit          ENABLE_ITYPE = 1'b1,
    parameter bit          ENABLE_JAL   = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam int unsigned TO_LAST    = TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic               op_lw_q;
    logic               illegal_q;
    logic               mem_err_q;
    logic               waiting_c;
    logic               timeout_c;
    logic               illegal_op_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter, latched load/store kind and sticky trap causes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            op_lw_q   <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting_c) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state_q == S_DECODE) begin
                op_lw_q <= (bus.opcode == OP_LW);
            end
            if (illegal_op_c) begin
                illegal_q <= 1'b1;
            end
            if (timeout_c) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    // A memory state traps on the last allowed waiting cycle unless mem_ready rises.
    always_comb begin
        state_d      = state_q;
        waiting_c    = 1'b0;
        timeout_c    = 1'b0;
        illegal_op_c = 1'b0;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready) begin
                    case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_MEM_WB;
                        default:  state_d = S_FETCH;
                    endcase
                end else begin
                    waiting_c = 1'b1;
                    if (TIMEOUT_EN && (wait_cnt == CNT_W'(TO_LAST))) begin
                        state_d   = S_TRAP;
                        timeout_c = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = ENABLE_ITYPE ? S_EXEC_I : S_TRAP;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_JAL:       state_d = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
                illegal_op_c = (state_d == S_TRAP);
            end
            S_MEM_ADDR: state_d = op_lw_q ? S_MEM_RD : S_MEM_WR;
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the registered state; forced low in reset.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 1'b0;
        bus.illegal    = 1'b0;
        bus.mem_err    = 1'b0;
        bus.state      = 4'd0;
        if (!rst) begin
            bus.state   = state_q;
            bus.illegal = illegal_q;
            bus.mem_err = mem_err_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b10;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b10;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_op    = 2'b01;
                    bus.pc_src    = 1'b1;
                    bus.pc_write  = bus.zero;
                end
                S_JAL: begin
                    bus.alu_src_b = 2'b01;
                    bus.reg_write = 1'b1;
                    bus.pc_src    = 1'b1;
                    bus.pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
